// File: rtl/fb_cmd_pkg.sv
// Shared types for the frame-buffer command sequencer: opcodes, FSM states,
// the queued 3-byte command record and small field-extraction helpers.
package fb_cmd_pkg;

  typedef enum logic [3:0] {
    OP_NOP         = 4'h0,
    OP_WRITE       = 4'h1,
    OP_FILL        = 4'h2,
    OP_SET_SCORE   = 4'h3,
    OP_SET_STATE   = 4'h4,
    OP_CLEAR_FLAGS = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL
  } state_e;

  typedef struct packed {
    logic [7:0] command;
    logic [7:0] databyte1;
    logic [7:0] databyte2;
  } cmd_t;

  localparam int ADDR_W = 10;

  function automatic logic [3:0] cmd_opcode(input cmd_t c);
    return c.command[7:4];
  endfunction

  // Ten-bit operand {ah, databyte1}, shared by WRITE addresses and SET_SCORE.
  function automatic logic [ADDR_W-1:0] cmd_addr(input cmd_t c);
    return {c.command[1:0], c.databyte1};
  endfunction

endpackage

// File: rtl/fb_cmd_ctrl_cmd_fifo.sv
// Small synchronous command FIFO; a push while full is accepted when a pop
// happens on the same edge, otherwise it is ignored (the caller flags it).
module cmd_fifo
  import fb_cmd_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  cmd_t wdata_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);

  cmd_t          mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the reset pointers/count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fb_cmd_ctrl.sv
// Command sequencer: catches the end of each SPI transaction, queues the
// command and executes it against the frame RAM write port and VGA registers.
module fb_cmd_ctrl
  import fb_cmd_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int CMD_DEPTH   = 4,
  parameter bit GATE_VBLANK = 1'b0
) (
  input  logic       clk,
  input  logic       resetB,
  input  logic       cs,
  input  logic [7:0] command,
  input  logic [7:0] databyte1,
  input  logic [7:0] databyte2,
  input  logic       vblank,
  output logic       we,
  output logic [9:0] waddr,
  output logic [7:0] wdata,
  output logic [9:0] score,
  output logic [2:0] game_state,
  output logic       busy,
  output logic       overflow,
  output logic       bad_cmd
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic cs_meta_q, cs_sync_q, cs_hist_q, cs_rise;

  // Synchronizer resets to the idle-high level so reset release never fakes a rising edge.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
      cs_hist_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the previous stage's old value.
      cs_meta_q <= cs;
      cs_sync_q <= cs_meta_q;
      cs_hist_q <= cs_sync_q;
    end
  end

  assign cs_rise = cs_sync_q & ~cs_hist_q;

  cmd_t push_cmd, head_cmd, cur_q;
  logic fifo_pop, fifo_full, fifo_empty, fifo_drop;

  assign push_cmd  = '{command: command, databyte1: databyte1, databyte2: databyte2};
  assign fifo_drop = cs_rise & fifo_full & ~fifo_pop;

  cmd_fifo #(
    .CMD_DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (resetB),
    .push_i  (cs_rise),
    .pop_i   (fifo_pop),
    .wdata_i (push_cmd),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  state_e            state_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic              write_ok;
  logic              we_q, busy_q, overflow_q, bad_cmd_q;
  logic [ADDR_W-1:0] waddr_q, score_q;
  logic [7:0]        wdata_q;
  logic [2:0]        game_state_q;

  assign write_ok = ~GATE_VBLANK | vblank;
  assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty;

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      fill_addr_q  <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      score_q      <= '0;
      game_state_q <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      bad_cmd_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      busy_q <= ~fifo_empty | (state_q != ST_IDLE);
      if (fifo_drop) overflow_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            cur_q <= head_cmd;
            case (cmd_opcode(head_cmd))
              OP_NOP: ;
              OP_WRITE: state_q <= ST_WRITE;
              OP_FILL: begin
                state_q     <= ST_FILL;
                fill_addr_q <= '0;
              end
              OP_SET_SCORE: score_q      <= cmd_addr(head_cmd);
              OP_SET_STATE: game_state_q <= head_cmd.databyte2[2:0];
              OP_CLEAR_FLAGS: begin
                overflow_q <= 1'b0;
                bad_cmd_q  <= 1'b0;
              end
              default: bad_cmd_q <= 1'b1;
            endcase
          end
        end

        ST_WRITE: begin
          if (write_ok) begin
            we_q    <= 1'b1;
            waddr_q <= cmd_addr(cur_q);
            wdata_q <= cur_q.databyte2;
            state_q <= ST_IDLE;
          end
        end

        ST_FILL: begin
          // A blocked cycle simply holds fill_addr, so the sweep resumes where it stopped.
          if (write_ok) begin
            we_q        <= 1'b1;
            waddr_q     <= fill_addr_q;
            wdata_q     <= cur_q.databyte2;
            fill_addr_q <= fill_addr_q + ADDR_W'(1);
            if (fill_addr_q == LAST_ADDR) state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign score      = score_q;
  assign game_state = game_state_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign bad_cmd    = bad_cmd_q;

endmodule

// File: tb/tb_fb_cmd_ctrl.sv
// Scoreboard bench for fb_cmd_ctrl: directed SPI commands queue expected RAM
// writes, and per-instance monitors compare every observed write in order.
module tb_fb_cmd_ctrl;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetB, resetB_g, cs, cs_g, vblank, vblank_g;
  logic [7:0] command, databyte1, databyte2;

  logic       we, busy, overflow, bad_cmd;
  logic [9:0] waddr, score;
  logic [7:0] wdata;
  logic [2:0] game_state;

  logic       we_g, busy_g, overflow_g, bad_cmd_g;
  logic [9:0] waddr_g, score_g;
  logic [7:0] wdata_g;
  logic [2:0] game_state_g;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  g_mon_en = 1'b1;
  int  cyc;
  wr_t exp_q[$];
  wr_t exp_g[$];

  fb_cmd_ctrl #(.DEPTH(1024), .CMD_DEPTH(4), .GATE_VBLANK(1'b0)) u_dut (
    .clk(clk), .resetB(resetB), .cs(cs), .command(command), .databyte1(databyte1),
    .databyte2(databyte2), .vblank(vblank), .we(we), .waddr(waddr), .wdata(wdata),
    .score(score), .game_state(game_state), .busy(busy), .overflow(overflow),
    .bad_cmd(bad_cmd)
  );

  fb_cmd_ctrl #(.DEPTH(16), .CMD_DEPTH(4), .GATE_VBLANK(1'b1)) u_gate (
    .clk(clk), .resetB(resetB_g), .cs(cs_g), .command(command), .databyte1(databyte1),
    .databyte2(databyte2), .vblank(vblank_g), .we(we_g), .waddr(waddr_g), .wdata(wdata_g),
    .score(score_g), .game_state(game_state_g), .busy(busy_g), .overflow(overflow_g),
    .bad_cmd(bad_cmd_g)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [9:0] a, input logic [7:0] d);
    return {a, d};
  endfunction

  // Bytes stay put from the cs rise until the next call, well past the push edge.
  task automatic spi_send(input bit gated, input logic [7:0] c, input logic [7:0] b1,
                          input logic [7:0] b2);
    repeat (4) @(posedge clk);
    #1;
    command   = c;
    databyte1 = b1;
    databyte2 = b2;
    if (gated) cs_g = 1'b0; else cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (gated) cs_g = 1'b1; else cs = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    check(name, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (resetB && we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut_unexpected_we: got write addr=0x%0h data=0x%0h, expected none",
                 waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        check("dut_write", 32'({waddr, wdata}), 32'({e.addr, e.data}));
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (resetB_g && g_mon_en && we_g) begin
      if (exp_g.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL gate_unexpected_we: got write addr=0x%0h data=0x%0h, expected none",
                 waddr_g, wdata_g);
      end else begin
        e = exp_g.pop_front();
        check("gate_write", 32'({waddr_g, wdata_g}), 32'({e.addr, e.data}));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetB = 1'b0; resetB_g = 1'b0;
    cs = 1'b1; cs_g = 1'b1;
    vblank = 1'b0; vblank_g = 1'b0;
    command = '0; databyte1 = '0; databyte2 = '0;
    repeat (3) @(posedge clk);
    #1;
    resetB = 1'b1; resetB_g = 1'b1;

    // Reset released with cs high: nothing may be queued.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_we", 32'(we), 0);
    end
    check("reset_waddr", 32'(waddr), 0);
    check("reset_wdata", 32'(wdata), 0);
    check("reset_score", 32'(score), 0);
    check("reset_game_state", 32'(game_state), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_bad_cmd", 32'(bad_cmd), 0);

    // Single WRITE; must land within 5 cycles of the cs rise.
    exp_q.push_back(mk(10'h234, 8'hA5));
    spi_send(1'b0, 8'h12, 8'h34, 8'hA5);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 6) begin
      @(posedge clk);
      cyc++;
    end
    check("write_within_5_cycles", 32'(exp_q.size()), 0);
    wait_done(20, "write_done");

    // NOP changes nothing and writes nothing.
    spi_send(1'b0, 8'h00, 8'h11, 8'h22);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("nop_busy", 32'(busy), 0);
    check("nop_bad_cmd", 32'(bad_cmd), 0);

    // Full FILL of 1024 cells.
    for (int a = 0; a < 1024; a++) exp_q.push_back(mk(10'(a), 8'h07));
    spi_send(1'b0, 8'h20, 8'h5A, 8'h07);
    wait_done(1100, "fill_done");
    check("fill_last_waddr", 32'(waddr), 32'h3FF);
    check("fill_last_wdata", 32'(wdata), 32'h07);

    // Five commands during a FILL: four execute in order, the fifth is dropped.
    for (int a = 0; a < 1024; a++) exp_q.push_back(mk(10'(a), 8'h55));
    spi_send(1'b0, 8'h20, 8'h00, 8'h55);
    exp_q.push_back(mk(10'h001, 8'h11));
    exp_q.push_back(mk(10'h3FF, 8'h22));
    exp_q.push_back(mk(10'h200, 8'h33));
    spi_send(1'b0, 8'h10, 8'h01, 8'h11);
    spi_send(1'b0, 8'h13, 8'hFF, 8'h22);
    spi_send(1'b0, 8'h31, 8'h23, 8'h00);
    spi_send(1'b0, 8'h12, 8'h00, 8'h33);
    spi_send(1'b0, 8'h11, 8'h11, 8'h44);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("overflow_set", 32'(overflow), 1);
    wait_done(1200, "fill_queue_done");
    check("queued_score", 32'(score), 32'h123);
    check("overflow_sticky", 32'(overflow), 1);
    spi_send(1'b0, 8'hF0, 8'h00, 8'h00);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("overflow_cleared", 32'(overflow), 0);

    // Register updates and an undefined opcode.
    spi_send(1'b0, 8'h33, 8'hE7, 8'h00);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("set_score", 32'(score), 32'h3E7);
    spi_send(1'b0, 8'h40, 8'h00, 8'h05);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("set_state", 32'(game_state), 5);
    check("score_hold", 32'(score), 32'h3E7);
    spi_send(1'b0, 8'h90, 8'h12, 8'h34);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bad_cmd_set", 32'(bad_cmd), 1);
    check("bad_cmd_idle", 32'(busy), 0);
    spi_send(1'b0, 8'hF0, 8'h00, 8'h00);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bad_cmd_cleared", 32'(bad_cmd), 0);
    check("state_hold", 32'(game_state), 5);

    // vblank-gated instance: WRITE waits for vblank.
    spi_send(1'b1, 8'h11, 8'h22, 8'h66);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("gate_no_we_blanked", 32'(we_g), 0);
    check("gate_busy_pending", 32'(busy_g), 1);
    exp_g.push_back(mk(10'h122, 8'h66));
    @(posedge clk);
    #1 vblank_g = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("gate_we_first_vblank_cycle", 32'(we_g), 1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((exp_g.size() != 0 || busy_g) && cyc < 20);
    check("gate_done", 32'(exp_g.size() == 0 && !busy_g), 1);

    // Reset in the middle of a FILL with a WRITE still queued.
    g_mon_en = 1'b0;
    spi_send(1'b1, 8'h20, 8'h00, 8'h09);
    spi_send(1'b1, 8'h10, 8'h05, 8'h77);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("gate_fill_active", 32'(we_g), 1);
    #1 resetB_g = 1'b0;
    #1;
    check("reset_mid_fill_we", 32'(we_g), 0);
    check("reset_mid_fill_busy", 32'(busy_g), 0);
    repeat (2) @(posedge clk);
    #1 resetB_g = 1'b1;
    g_mon_en = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("after_reset_fifo_empty", 32'(busy_g), 0);
    check("after_reset_we", 32'(we_g), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_cmd_ctrl.md
Name: fb_cmd_ctrl

Overview:
- Command sequencer between the SPI receiver and the dual-port frame RAM.
- Detects end of each SPI transaction (cs rising) and queues the received 3-byte command in a small FIFO.
- Executes queued commands as single-cell writes, whole-RAM fills, score updates or game-state updates.
- Drives the write port of the frame RAM (we/waddr/wdata) and the score/state inputs of the VGA core.

Parameters:
- DEPTH, 1024, number of frame RAM cells written by FILL (addresses 0..DEPTH-1, DEPTH ≤ 1024)
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥ 2)
- GATE_VBLANK, 0, 1 = RAM writes are only issued while vblank is high

Ports:
- clk  in  1  system clock
- resetB  in  1  asynchronous active-low reset
- cs  in  1  SPI chip select, asynchronous to clk, idle high
- command  in  8  SPI command byte, stable while cs is high
- databyte1  in  8  SPI data byte 1, stable while cs is high
- databyte2  in  8  SPI data byte 2, stable while cs is high
- vblank  in  1  vertical blanking from the VGA core
- we  out  1  frame RAM write enable
- waddr  out  10  frame RAM write address
- wdata  out  8  frame RAM write data
- score  out  10  score to the VGA core
- game_state  out  3  state to the VGA core
- busy  out  1  FIFO not empty or FSM not IDLE
- overflow  out  1  sticky: a command was dropped because the FIFO was full
- bad_cmd  out  1  sticky: an undefined opcode was popped

Behaviour:
- Reset (resetB low, async):
  - All outputs 0; FIFO empty; FSM in IDLE.
  - cs synchronizer flops reset to 1, so releasing reset while cs is high does not create a false edge.
- cs synchronizer:
  - Two-flop sync plus one history flop. cs_rise = sync2 & ~hist.
  - On the clk edge where cs_rise is 1, {command, databyte1, databyte2} are pushed into the FIFO (bytes are static by then).
- FIFO overflow: a push while full is dropped and overflow is set, except when a pop occurs on the same edge; then the push is accepted.
- Opcode = command[7:4]; ah = command[1:0].
  - 0x0 NOP: no effect.
  - 0x1 WRITE: waddr = {ah, databyte1}, wdata = databyte2, one-cycle we.
  - 0x2 FILL: writes databyte2 to addresses 0..DEPTH-1, one per cycle.
  - 0x3 SET_SCORE: score = {ah, databyte1}.
  - 0x4 SET_STATE: game_state = databyte2[2:0].
  - 0xF CLEAR_FLAGS: overflow = 0, bad_cmd = 0.
  - Any other opcode: dropped, bad_cmd = 1.
- FSM states IDLE, WRITE, FILL.
  - IDLE, FIFO not empty: pop the head into the cur register.
    - WRITE and FILL go to their states.
    - SET_SCORE, SET_STATE and CLEAR_FLAGS take effect on the pop edge and stay in IDLE.
  - WRITE, write allowed: we = 1 for one cycle with the addr/data from cur, then IDLE.
  - FILL, starting at fill_addr = 0: each allowed cycle drives we = 1, waddr = fill_addr, wdata = cur data, then increments fill_addr. After writing DEPTH-1, go to IDLE.
  - Write allowed = ~GATE_VBLANK | vblank. When not allowed, the FSM holds state and fill_addr, and we = 0.
- Outputs: we, waddr and wdata are registered. Latency from the pop edge to the we-high cycle is 1 cycle when writes are allowed.
- Ordering: commands execute strictly in FIFO order. At most one pop per cycle, only in IDLE.
- Busy: busy deasserts the cycle after the last FILL/WRITE write completes with the FIFO empty.
- Hold values: score and game_state hold their values until the next SET command.
- Reset mid-FILL: the fill aborts immediately and the queued commands are discarded.

Decomposition:
- Package fb_cmd_pkg: opcode enum (OP_NOP, OP_WRITE, OP_FILL, OP_SET_SCORE, OP_SET_STATE, OP_CLEAR_FLAGS), FSM state enum, cmd_t struct {command, databyte1, databyte2}.
- Sub-module cmd_fifo: synchronous FIFO, parameter CMD_DEPTH, with push/pop/full/empty and same-cycle push-on-full-with-pop support.

Test Plan:
- Reset with cs high, then release → no push. Outputs stay 0 and busy = 0 for 20 cycles.
- SPI command 0x12, 0x34, 0xA5 (cs rise) → exactly one cycle with we = 1, waddr = 0x234, wdata = 0xA5, within 5 cycles of the cs rise.
- FILL 0x20, xx, 0x07 with DEPTH = 1024 → 1024 consecutive we cycles, waddr 0..1023 ascending, wdata = 0x07, then busy = 0.
- During FILL, send five commands (CMD_DEPTH = 4) → overflow = 1, the fifth is dropped, and the first four execute in order after the fill. Then 0xF0 clears overflow.
- SET_SCORE 0x33, 0xE7 → score = 0x3E7. SET_STATE 0x40, xx, 0x05 → game_state = 5. Opcode 0x9 → bad_cmd = 1 with no write.
- GATE_VBLANK = 1, WRITE issued with vblank low → we stays 0. The write occurs on the first cycle after vblank goes high. Assert resetB low mid-FILL → we = 0 immediately and the FIFO is empty.
